wb_uart_tx_slave: RTL and testbench
===================================

Name: wb_uart_tx_slave

Overview:
Wishbone classic-cycle responder for the UART slot at 0x1000_0000–0x1000_0FFF behind the system interconnect. It accepts CPU writes of transmit bytes into a small FIFO and serialises them as 8N1 on a TX line. It also exposes status and baud-divisor registers. The interconnect forwards the word-offset address bits addr[3:2] to this block alongside the UART strobe/cycle signals.

Parameters:
CLK_DIV_DEFAULT, 868, reset value of the divisor register (clock cycles per bit; 100 MHz / 115200).
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
wb_cyc  input  1  bus cycle valid
wb_stb  input  1  strobe
wb_we  input  1  1=write, 0=read
wb_addr  input  2  register select (byte offset / 4)
wb_data_in  input  32  write data
wb_data_out  output  32  read data, registered
wb_ack  output  1  transfer acknowledge, registered
uart_tx  output  1  serial out, idle high
tx_irq  output  1  level high when FIFO empty and transmitter idle

Behaviour:
- Reset (async, immediate): wb_ack=0, wb_data_out=0, uart_tx=1, FIFO empty, divisor=CLK_DIV_DEFAULT, overflow=0, FSM=IDLE, tx_irq=1. Reset mid-frame aborts the frame; uart_tx returns high without waiting for a clock edge.
- Handshake: wb_ack(next) = wb_cyc & wb_stb & ~wb_ack. ACK goes high one cycle after the request is sampled and stays high for exactly one cycle. A held strobe therefore yields ack every other cycle.
- Register side effects and the wb_data_out update occur only on the edge where wb_ack rises: once per transfer. If cyc or stb drops before that edge, the transfer is cancelled with no side effect.
- wb_data_out holds its value when wb_ack is low. On a write acknowledge, wb_data_out=0.
- Register map:
  - 0 TXDATA (W): pushes wb_data_in[7:0]. If the FIFO is full, judged on the pre-edge count, the push is dropped and overflow is set even if a pop occurs on the same edge. Reads return 0.
  - 1 STATUS: read layout is [0] busy (FSM≠IDLE), [1] fifo_full, [2] fifo_empty, [3] overflow sticky, [8+:5] fifo_count, all other bits 0. Write with bit3=1 clears overflow. Other written bits are ignored.
  - 2 DIVISOR (RW): bits[15:0]. A written value of 0 is stored as 1. Reads return the stored value zero-extended.
  - 3 reserved: reads 0, writes ignored, still acknowledged.
- Status reads reflect state before any same-edge FIFO pop or push.
- TX FSM states and transitions:
  - IDLE: on any cycle with FIFO non-empty, pop the byte into the shift register, latch the divisor into the bit timer, and go to START.
  - START: uart_tx=0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, DIV cycles each; bit counter 0..7, then STOP.
  - STOP: uart_tx=1 for DIV cycles, then IDLE.
- Frame length = 10·DIV cycles. Back-to-back frames have exactly one idle cycle (uart_tx=1) between them.
- A divisor change mid-frame takes effect on the next frame only.
- A push to an empty FIFO while IDLE begins START on the cycle after the pop. uart_tx falls 2 cycles after the write-ack edge.
- FIFO uses wrapping read/write pointers and a count of 0..FIFO_DEPTH. Simultaneous push and pop (when not full) leaves the count unchanged.
- tx_irq = fifo_empty & (FSM==IDLE), registered from state.

Test Plan:
- Reset, then read STATUS and DIVISOR -> STATUS=0x0000_0004, DIVISOR=868, uart_tx=1, tx_irq=1; each read is acknowledged one cycle after stb and for exactly one cycle.
- Write DIVISOR=4, then TXDATA=0x55 -> uart_tx is 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop bit 1 for 4 cycles; total 40 cycles; tx_irq drops during the frame and returns high after it.
- DIVISOR=4; write 9 bytes 0x00..0x08 back-to-back before the first pop -> 9th dropped; STATUS shows overflow=1, full=1, count=8; write STATUS 0x8 -> overflow=0; the serial stream carries 0x00..0x07, each frame separated by 1 idle cycle.
- Write DIVISOR=0 -> read returns 1; send 0xA3 -> each bit lasts 1 cycle, frame lasts 10 cycles.
- Assert stb for 1 cycle then drop it before ack on a TXDATA write -> no ack, no push; STATUS count stays 0.
- Assert rst mid-DATA bit -> uart_tx=1 immediately, FIFO empty, divisor=868; a subsequent write transmits normally.

Source files
------------

// File: rtl/wb_uart_tx_slave.sv
// wb_uart_tx_slave
//   Wishbone classic-cycle UART transmitter slot. CPU writes bytes into a
//   small TX FIFO; a bit-timer FSM serialises them as 8N1 on uart_tx.
//
//   Ports:
//     clk, rst          system clock, asynchronous active-high reset
//     wb_cyc, wb_stb    bus cycle / strobe
//     wb_we             1 = write, 0 = read
//     wb_addr[1:0]      register select: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved
//     wb_data_in[31:0]  write data
//     wb_data_out[31:0] registered read data (0 on write acks, holds otherwise)
//     wb_ack            registered one-cycle acknowledge
//     uart_tx           serial output, idle high
//     tx_irq            high while FIFO empty and transmitter idle
module wb_uart_tx_slave #(
    parameter int CLK_DIV_DEFAULT = 868,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_data_in,
    output logic [31:0] wb_data_out,
    output logic        wb_ack,
    output logic        uart_tx,
    output logic        tx_irq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic [15:0]   divisor, frame_div, timer;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          overflow;
    logic [31:0]   rdata;

    logic req, wr_txdata, wr_status, wr_div;
    logic fifo_full, fifo_empty, push, pop, timer_done;

    logic unused_bits;
    assign unused_bits = ^wb_data_in[31:16];

    // A request is taken only on the edge where ack rises, so each
    // transfer has exactly one side effect.
    assign req        = wb_cyc & wb_stb & ~wb_ack;
    assign wr_txdata  = req & wb_we & (wb_addr == 2'd0);
    assign wr_status  = req & wb_we & (wb_addr == 2'd1);
    assign wr_div     = req & wb_we & (wb_addr == 2'd2);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = wr_txdata & ~fifo_full;
    assign timer_done = (timer == 16'd0);

    // next-state logic
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (!fifo_empty) begin
                       pop     = 1'b1;
                       state_d = START;
                   end
            START: if (timer_done) state_d = DATA;
            DATA:  if (timer_done && bitcnt == 3'd7) state_d = STOP;
            STOP:  if (timer_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CW'(1);
        else if (!push && pop) count_d = count - CW'(1);
    end

    // read mux reflects pre-edge state
    always_comb begin
        rdata = '0;
        case (wb_addr)
            2'd1: begin
                rdata[0]    = (state_q != IDLE);
                rdata[1]    = fifo_full;
                rdata[2]    = fifo_empty;
                rdata[3]    = overflow;
                rdata[12:8] = 5'(count);
            end
            2'd2:    rdata[15:0] = divisor;
            default: rdata = '0;
        endcase
    end

    // bus side and registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            divisor     <= 16'(CLK_DIV_DEFAULT);
            overflow    <= 1'b0;
        end else begin
            wb_ack <= req;
            if (req) wb_data_out <= wb_we ? 32'd0 : rdata;
            if (wr_div)
                divisor <= (wb_data_in[15:0] == 16'd0) ? 16'd1 : wb_data_in[15:0];
            // full is judged before any same-edge pop
            if (wr_txdata && fifo_full)          overflow <= 1'b1;
            else if (wr_status && wb_data_in[3]) overflow <= 1'b0;
        end
    end

    // FIFO storage needs no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wb_data_in[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
        end
    end

    // bit timer / shifter; the divisor is latched per frame so a
    // mid-frame divisor write only affects the following frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            frame_div <= 16'd1;
            timer     <= '0;
            bitcnt    <= '0;
        end else if (pop) begin
            shreg     <= mem[rd_ptr];
            frame_div <= divisor;
            timer     <= divisor - 16'd1;
            bitcnt    <= '0;
        end else if (state_q != IDLE) begin
            if (timer_done) begin
                timer <= frame_div - 16'd1;
                if (state_q == DATA) begin
                    shreg  <= shreg >> 1;
                    bitcnt <= bitcnt + 3'd1;
                end
            end else begin
                timer <= timer - 16'd1;
            end
        end
    end

    // uart_tx is registered from the current state, so the line lags the
    // FSM by one cycle; the IDLE cycle that pops gives the inter-frame gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx <= 1'b1;
            tx_irq  <= 1'b1;
        end else begin
            case (state_q)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shreg[0];
                default: uart_tx <= 1'b1;
            endcase
            tx_irq <= (count_d == '0) && (state_d == IDLE);
        end
    end
endmodule

// File: tb/tb_wb_uart_tx_slave.sv
module tb_wb_uart_tx_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [1:0]  wb_addr = 2'd0;
    logic [31:0] wb_data_in = 32'd0;
    logic [31:0] wb_data_out;
    logic        wb_ack, uart_tx, tx_irq;

    int total = 0;
    int bad   = 0;

    wb_uart_tx_slave #(.CLK_DIV_DEFAULT(868), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
        .wb_ack(wb_ack), .uart_tx(uart_tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // one classic transfer; returns one cycle after the ack edge
    task automatic xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string nm);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_data_in = d;
        @(posedge clk); #1;
        chk({nm, "_ack"}, {31'd0, wb_ack}, 32'd1);
        chk({nm, "_data"}, wb_data_out, exp);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_ackdrop"}, {31'd0, wb_ack}, 32'd0);
        chk({nm, "_hold"}, wb_data_out, exp);
    endtask

    // samples 10*div line cycles starting at frame cycle 'first'
    task automatic check_frame(input logic [7:0] b, input int div, input int first,
                               input string nm);
        for (int k = first; k < 10 * div; k++) begin
            logic e;
            int   bi;
            bi = k / div;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi-1];
            @(posedge clk); #1;
            chk($sformatf("%s_k%0d", nm, k), {31'd0, uart_tx}, {31'd0, e});
            if (k == first) chk({nm, "_irq_low"}, {31'd0, tx_irq}, 32'd0);
        end
    endtask

    task automatic check_idle(input string nm);
        @(posedge clk); #1;
        chk(nm, {31'd0, uart_tx}, 32'd1);
    endtask

    task automatic wait_tx(input logic v, input int lim, input string nm);
        int n = 0;
        while (uart_tx !== v && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, {31'd0, uart_tx}, {31'd0, v});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'd1, 32'h0,         32'h4};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         32'd868};
        vecs[2]  = '{1'b0, 2'd3, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b1, 2'd2, 32'h0001_0007, 32'h0};
        vecs[6]  = '{1'b0, 2'd2, 32'h0,         32'h7};
        vecs[7]  = '{1'b1, 2'd1, 32'hFFFF_FFF7, 32'h0};
        vecs[8]  = '{1'b0, 2'd1, 32'h0,         32'h4};
        vecs[9]  = '{1'b1, 2'd2, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,         32'h1};
        vecs[11] = '{1'b1, 2'd2, 32'h4,         32'h0};
        vecs[12] = '{1'b0, 2'd2, 32'h0,         32'h4};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  {31'd0, wb_ack},  32'd0);
        chk("rst_data", wb_data_out,      32'd0);
        chk("rst_tx",   {31'd0, uart_tx}, 32'd1);
        chk("rst_irq",  {31'd0, tx_irq},  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // register map vectors
        for (int i = 0; i < 13; i++)
            xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                 $sformatf("vec%0d", i));

        // held strobe: ack every other cycle
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ack%0d", i), {31'd0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        chk("held_data", wb_data_out, 32'h4);

        // single frame 0x55 at DIV=4
        xfer(1'b1, 2'd0, 32'h55, 32'h0, "tx55");
        chk("f55_idle", {31'd0, uart_tx}, 32'd1);
        check_frame(8'h55, 4, 0, "f55");
        @(posedge clk); #1;
        chk("f55_after_tx",  {31'd0, uart_tx}, 32'd1);
        chk("f55_after_irq", {31'd0, tx_irq},  32'd1);

        // strobe withdrawn before any sampling edge: no ack, no push
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 2'd0; wb_data_in = 32'h77;
        #7;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("cancel_ack%0d", i), {31'd0, wb_ack}, 32'd0);
            chk($sformatf("cancel_tx%0d", i),  {31'd0, uart_tx}, 32'd1);
        end
        xfer(1'b0, 2'd1, 32'h0, 32'h4, "cancel_status");

        // overflow: a slow dummy frame keeps the FIFO from draining
        xfer(1'b1, 2'd2, 32'd100, 32'h0, "ovf_div100");
        xfer(1'b1, 2'd0, 32'hFF,  32'h0, "ovf_dummy");
        xfer(1'b1, 2'd2, 32'd4,   32'h0, "ovf_div4");
        for (int i = 0; i < 9; i++)
            xfer(1'b1, 2'd0, i, 32'h0, $sformatf("ovf_push%0d", i));
        xfer(1'b0, 2'd1, 32'h0, 32'h80B, "ovf_status");
        xfer(1'b1, 2'd1, 32'h8, 32'h0,   "ovf_clear");
        xfer(1'b0, 2'd1, 32'h0, 32'h803, "ovf_status2");
        wait_tx(1'b1, 2000, "ovf_wait_hi");
        wait_tx(1'b0, 2000, "ovf_wait_start");
        check_frame(8'h00, 4, 1, "ovf_f0");
        for (int b = 1; b < 8; b++) begin
            check_idle($sformatf("ovf_gap%0d", b));
            check_frame(8'(b), 4, 0, $sformatf("ovf_f%0d", b));
        end
        check_idle("ovf_end_idle");
        chk("ovf_end_irq", {31'd0, tx_irq}, 32'd1);
        xfer(1'b0, 2'd1, 32'h0, 32'h4, "ovf_status_end");

        // divisor 0 is stored as 1
        xfer(1'b1, 2'd2, 32'h0,  32'h0, "div0_wr");
        xfer(1'b0, 2'd2, 32'h0,  32'h1, "div0_rd");
        xfer(1'b1, 2'd0, 32'hA3, 32'h0, "txa3");
        chk("fa3_idle", {31'd0, uart_tx}, 32'd1);
        check_frame(8'hA3, 1, 0, "fa3");
        @(posedge clk); #1;
        chk("fa3_after_tx",  {31'd0, uart_tx}, 32'd1);
        chk("fa3_after_irq", {31'd0, tx_irq},  32'd1);

        // reset mid-DATA aborts the frame immediately
        xfer(1'b1, 2'd2, 32'd20, 32'h0, "rst_div20");
        xfer(1'b1, 2'd0, 32'h00, 32'h0, "rst_tx00");
        repeat (40) @(posedge clk);
        #1;
        chk("pre_rst_low", {31'd0, uart_tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx",  {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_irq", {31'd0, tx_irq},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 2'd1, 32'h0, 32'h4,    "post_rst_status");
        xfer(1'b0, 2'd2, 32'h0, 32'd868,  "post_rst_div");
        chk("post_rst_tx", {31'd0, uart_tx}, 32'd1);
        xfer(1'b1, 2'd2, 32'd2,  32'h0, "post_rst_div2");
        xfer(1'b1, 2'd0, 32'h3C, 32'h0, "post_rst_tx3c");
        chk("f3c_idle", {31'd0, uart_tx}, 32'd1);
        check_frame(8'h3C, 2, 0, "f3c");
        @(posedge clk); #1;
        chk("f3c_after_irq", {31'd0, tx_irq}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
